// File: rtl/bus_xfer_sequencer.sv
// Queues register-transfer commands and sequences them onto a single-bus datapath:
// one DRIVE cycle per command, with an optional memory wait when the source is MDR.
module bus_xfer_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_src,
  input  logic [4:0]  cmd_dst,
  output logic [23:0] bus_sel,
  output logic [23:0] load_en,
  output logic        mem_read,
  input  logic        mem_done,
  output logic        busy,
  output logic [2:0]  fifo_count,
  output logic        err_illegal,
  output logic        err_timeout,
  output logic [1:0]  state_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [4:0] SRC_MDR = 5'd21;

  typedef enum logic [1:0] {IDLE = 2'd0, MEMWAIT = 2'd1, DRIVE = 2'd2} state_t;

  state_t          state;
  logic [4:0]      src_mem [FIFO_DEPTH];
  logic [4:0]      dst_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [2:0]      count;
  logic [TW-1:0]   wait_cnt;

  logic            legal;
  logic            accept;
  logic            push;
  logic            pop;
  logic            timeout_hit;
  logic [4:0]      head_src;
  logic [4:0]      head_dst;
  logic [4:0]      next_head_src;
  logic            more_after_pop;

  // Handshake: a command transfers on any edge where cmd_valid && cmd_ready;
  // illegal commands are consumed by that handshake but never stored.
  assign cmd_ready   = clear && (count < 3'(FIFO_DEPTH));
  assign legal       = (cmd_src <= 5'd23) && (cmd_dst <= 5'd23);
  assign accept      = cmd_valid && cmd_ready;
  assign push        = accept && legal;

  assign head_src    = src_mem[rd_ptr];
  assign head_dst    = dst_mem[rd_ptr];
  assign timeout_hit = (state == MEMWAIT) && !mem_done && (wait_cnt == TW'(MEM_TIMEOUT - 1));
  assign pop         = (state == DRIVE) || timeout_hit;

  // The entry that becomes head after a DRIVE pop: either the next stored one
  // or, when the queue would otherwise run dry, the command pushed on this edge.
  assign more_after_pop = (count > 3'd1) || push;
  assign next_head_src  = (count > 3'd1) ? src_mem[rd_ptr + AW'(1)] : cmd_src;

  assign bus_sel    = (state == DRIVE) ? (24'd1 << head_src) : 24'd0;
  assign load_en    = (state == DRIVE) ? (24'd1 << head_dst) : 24'd0;
  assign mem_read   = (state == MEMWAIT);
  assign busy       = (count != 3'd0) || (state != IDLE);
  assign fifo_count = count;
  assign state_dbg  = state;

  always_ff @(posedge clock) begin
    if (push) begin
      src_mem[wr_ptr] <= cmd_src;
      dst_mem[wr_ptr] <= cmd_dst;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      wait_cnt    <= '0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {2'b00, push} - {2'b00, pop};
      if (accept && !legal) err_illegal <= 1'b1;

      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (count != 3'd0) state <= (head_src == SRC_MDR) ? MEMWAIT : DRIVE;
        end
        MEMWAIT: begin
          if (mem_done) begin
            state <= DRIVE;
          end else if (timeout_hit) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        DRIVE: begin
          wait_cnt <= '0;
          if (more_after_pop) state <= (next_head_src == SRC_MDR) ? MEMWAIT : DRIVE;
          else                state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bus_xfer_sequencer.md
BUS_XFER_SEQUENCER -- requirements
Module: bus_xfer_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, command queue depth (power of two).
REQ-002 Parameter MEM_TIMEOUT, default 16, max wait cycles for memory-read completion.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 clear  in  1  asynchronous active-low reset.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  command queue can accept.
REQ-008 cmd_src  in  5  bus source index: 0-15 R0-R15, 16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 PC, 21 MDR, 22 InPort, 23 C_sign_extended.
REQ-009 cmd_dst  in  5  destination index: 0-15 R0-R15, 16 HI, 17 LO, 18 PC, 19 MAR, 20 MDR, 21 Y, 22 IR, 23 OutPort.
REQ-010 bus_sel  out  24  one-hot source select to the bus multiplexer encoder input.
REQ-011 load_en  out  24  one-hot destination load enable.
REQ-012 mem_read  out  1  memory read request for MDR.
REQ-013 mem_done  in  1  memory read complete, single-cycle pulse.
REQ-014 busy  out  1  high when the FIFO is non-empty or state is not IDLE.
REQ-015 fifo_count  out  3  queued entries, 0..FIFO_DEPTH.
REQ-016 err_illegal  out  1  sticky: an illegal command was rejected.
REQ-017 err_timeout  out  1  sticky: a memory wait timed out.

Function
REQ-018 cmd_ready SHALL equal (fifo_count < FIFO_DEPTH); a push SHALL occur only on cmd_valid && cmd_ready at a clock edge, even if a pop occurs in the same cycle.
REQ-019 A command with cmd_src > 23 or cmd_dst > 23 SHALL be consumed but not enqueued, and SHALL set err_illegal.
REQ-020 The FIFO SHALL be in-order with wrapping read/write pointers; a simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-021 The FSM SHALL have states IDLE, MEMWAIT, and DRIVE.
REQ-022 IDLE: if the FIFO is non-empty at an edge, go to MEMWAIT when head src==21, otherwise go to DRIVE; if empty, stay in IDLE.
REQ-023 DRIVE lasts exactly one cycle: bus_sel=1<<head.src and load_en=1<<head.dst, both combinational from the state and the FIFO head; the head pops at the exiting edge.
REQ-024 Exit from DRIVE: if the FIFO will hold another entry after the pop (including a same-edge push), go directly to DRIVE or MEMWAIT per REQ-022, giving one transfer per cycle back-to-back; otherwise go to IDLE.
REQ-025 Outside DRIVE, bus_sel and load_en SHALL be all-zero.
REQ-026 MEMWAIT: mem_read=1; a wait counter starts at 0 on entry and increments each cycle; mem_done=1 at an edge moves the FSM to DRIVE (same head entry).
REQ-027 If the counter reaches MEM_TIMEOUT-1 without mem_done, the FSM SHALL set err_timeout, pop the head without driving it, and go to IDLE.
REQ-028 If mem_done and timeout coincide, mem_done wins (DRIVE, no error).
REQ-029 mem_done outside MEMWAIT SHALL be ignored.
REQ-030 Latency: a command accepted at edge k into an empty, IDLE block SHALL be driven in the cycle after edge k+1 (non-MDR source).
REQ-031 err_illegal and err_timeout SHALL clear only on reset.

Reset
REQ-032 clear=0 SHALL immediately force state IDLE, both pointers and fifo_count 0, the wait counter 0, and all outputs 0 except cmd_ready; queued commands are discarded.
REQ-033 cmd_ready SHALL read 0 while clear=0 and 1 on the first cycle after clear deasserts.
REQ-034 Reset asserted in MEMWAIT or DRIVE SHALL abort the transfer with no further load_en pulse.

Verification
REQ-035 Push {src=4,dst=7} into an idle block -> one cycle later bus_sel=0x000010 and load_en=0x000080 for exactly one cycle; then busy=0.
REQ-036 Push 5 commands back-to-back while the FSM is held in MEMWAIT -> the 5th is stalled with cmd_ready=0 at fifo_count=4; after release, 4 consecutive DRIVE cycles occur in order.
REQ-037 Push {src=21,dst=22}, then pulse mem_done 3 cycles after mem_read rises -> the next cycle shows bus_sel=0x200000 and load_en=0x400000; err_timeout stays 0.
REQ-038 Push {src=21,dst=0} with no mem_done -> mem_read is high for 16 cycles, then err_timeout=1, fifo_count=0, and load_en is never asserted.
REQ-039 Push {src=25,dst=3} -> err_illegal=1 and fifo_count stays 0; a following legal command still executes.
REQ-040 Assert clear in mid-DRIVE with 3 entries queued -> all outputs are 0 immediately and fifo_count=0; after release, no stale transfer occurs.
